sync_to_4phase_bridge: RTL and testbench

- Clocked adapter that sits directly upstream of the four-way request fork in the asynchronous pipeline.
- Accepts words from a synchronous valid/ready stream and issues them as bundled data with a 4-phase (return-to-zero) req/ack handshake on req_o/ack_i.
- The fork's combined acknowledge drives ack_i. Data is registered before req_o rises (bundled-data setup), and ack_i is synchronised into the clock domain.
- A watchdog flags handshakes that stall.

---
 rtl/sync_to_4phase_bridge.sv | 134 +++++++++++++
 tb/tb_sync_to_4phase_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_to_4phase_bridge.sv
// Synchronous valid/ready to 4-phase bundled-data bridge feeding the request fork.
// ack_i is synchronised into clk_i; a sticky watchdog flags stalled ack edges.
module sync_to_4phase_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  input  logic                  clear_i,
  output logic [2:0]            dbg_state_o
);

  // Handshake: a word moves on a rising clk_i edge where valid_i && ready_o;
  // ready_o is decoded from state only. On the async side req_o rises with
  // data_o already stable for a cycle, ack_i follows, then both return to zero.

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_SETUP    = 3'd2,
    S_REQ_UP   = 3'd3,
    S_REQ_DOWN = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    req_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]  fill_q;
  logic                    ack_s;
  logic                    primed;

  assign ack_s  = sync_q[SYNC_STAGES-1];
  // fill_q tracks when ack_s reflects a real sample rather than the reset zero,
  // so INIT cannot leave while the receiver still holds ack high.
  assign primed = fill_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (primed && !ack_s) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (valid_i) begin
            data_q  <= data_i;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          req_q   <= 1'b1;
          state_q <= S_REQ_UP;
        end
        S_REQ_UP: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= S_REQ_DOWN;
          end
        end
        S_REQ_DOWN: begin
          if (!ack_s) state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_INIT);
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign dbg_state_o = state_q;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q;
      logic          to_q;
      logic          waiting;

      // Not waiting on the cycle that enters REQ_UP or REQ_DOWN, which clears the count.
      assign waiting = ((state_q == S_REQ_UP) && !ack_s) ||
                       ((state_q == S_REQ_DOWN) && ack_s);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          to_q  <= 1'b0;
        end else begin
          if (waiting) begin
            if (cnt_q != LIMIT) cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
          if (waiting && (cnt_q == LIMIT - 1'b1)) to_q <= 1'b1;
          else if (clear_i)                       to_q <= 1'b0;
        end
      end

      assign timeout_o = to_q;
    end else begin : g_no_wdog
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_sync_to_4phase_bridge.sv
// Directed bench for sync_to_4phase_bridge: cycle table for one word plus
// hand sequences for back-to-back, stall/timeout, reset mid-handshake and 3-stage sync.
module tb_sync_to_4phase_bridge;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni;

  // main DUT: SYNC_STAGES=2, TIMEOUT_CYCLES=16
  logic        valid_i, ready_o, req_o, ack_i, busy_o, timeout_o, clear_i;
  logic [31:0] data_i, data_o;
  logic [2:0]  state_o;
  logic        echo, ack_force;
  assign ack_i = echo ? req_o : ack_force;

  sync_to_4phase_bridge #(.DATA_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .req_o(req_o), .ack_i(ack_i), .data_o(data_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .clear_i(clear_i), .dbg_state_o(state_o)
  );

  // second DUT: SYNC_STAGES=3, watchdog disabled, ack always echoes req
  logic        valid3, ready3, req3, busy3, timeout3;
  logic [31:0] data3_i, data3_o;
  logic [2:0]  state3;

  sync_to_4phase_bridge #(.DATA_WIDTH(32), .SYNC_STAGES(3), .TIMEOUT_CYCLES(0)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid3), .ready_o(ready3), .data_i(data3_i),
    .req_o(req3), .ack_i(req3), .data_o(data3_o), .busy_o(busy3),
    .timeout_o(timeout3), .clear_i(1'b0), .dbg_state_o(state3)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: accepted words queued, checked against data_o when req_o rises
  logic [31:0] exp_q[$];
  int          acc_cyc[$];
  int          acc_cnt = 0;
  int          rise_cnt = 0;
  logic        req_prev = 1'b0;
  logic [31:0] held;

  always @(negedge clk) begin
    if (!rst_ni) begin
      req_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (req_o && !req_prev) begin
        rise_cnt++;
        check("rise_has_accept", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("bundled_data", data_o, exp_q.pop_front());
        held = data_o;
      end else if (req_o && req_prev) begin
        check("data_stable_req", data_o, held);
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(data_i);
        acc_cyc.push_back(cyc);
        acc_cnt++;
      end
      req_prev = req_o;
    end
  end

  // driver helpers; every wait is bounded
  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    check("wait_ready", ready_o, 1);
  endtask

  task automatic wait_req(input logic val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (req_o == val) break;
      @(posedge clk); #1;
    end
    check("wait_req", req_o, val);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        req;
    logic        ready;
    logic        busy;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[9];

  int rise0, acc0, a0;

  initial begin
    // row k: inputs before edge N+k, expected outputs after edge N+k
    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'hFFFF0000, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 32'h13579BDF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 32'h2468ACE0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};

    rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; clear_i = 1'b0;
    echo = 1'b1; ack_force = 1'b0; valid3 = 1'b0; data3_i = '0;

    #3;
    check("rst_req", req_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", data_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_state", state_o, 0);
    check("rst_ready3", ready3, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // single word through the cycle table
    wait_ready(20);
    for (int i = 0; i < 9; i++) begin
      valid_i = vecs[i].valid;
      data_i  = vecs[i].data;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_req", i), req_o, vecs[i].req);
      check($sformatf("tbl%0d_ready", i), ready_o, vecs[i].ready);
      check($sformatf("tbl%0d_busy", i), busy_o, vecs[i].busy);
      check($sformatf("tbl%0d_data", i), data_o, vecs[i].exp_data);
    end

    // back-to-back with valid_i held
    rise0 = rise_cnt; acc0 = acc_cnt; a0 = acc_cyc.size();
    valid_i = 1'b1; data_i = 32'h11111111;
    @(posedge clk); #1;
    data_i = 32'h22222222;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt >= acc0 + 2) break;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check("b2b_two_accepts", acc_cnt - acc0, 2);
    wait_ready(30);
    check("b2b_two_pulses", rise_cnt - rise0, 2);
    if (acc_cyc.size() >= a0 + 2) check("b2b_spacing", acc_cyc[a0+1] - acc_cyc[a0], 8);
    else check("b2b_spacing_recorded", acc_cyc.size() - a0, 2);
    check("b2b_last_data", data_o, 32'h22222222);

    // stall with ack held low: timeout, clear, then complete
    echo = 1'b0; ack_force = 1'b0;
    rise0 = rise_cnt; acc0 = acc_cnt;
    valid_i = 1'b1; data_i = 32'hA5A50001;
    @(posedge clk); #1;
    for (int k = 1; k <= 17; k++) begin
      data_i = $urandom;
      @(posedge clk); #1;
      if (k == 16) check("to_before_16", timeout_o, 0);
    end
    check("to_set", timeout_o, 1);
    check("to_req_held", req_o, 1);
    check("to_state_req_up", state_o, 3);
    check("stall_data", data_o, 32'hA5A50001);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    check("to_cleared", timeout_o, 0);
    check("to_req_still", req_o, 1);
    valid_i = 1'b0;
    ack_force = 1'b1;
    wait_req(1'b0, 20);
    ack_force = 1'b0;
    wait_ready(20);
    check("stall_data_after", data_o, 32'hA5A50001);
    check("stall_one_accept", acc_cnt - acc0, 1);
    check("stall_accept_eq_rise", acc_cnt - acc0, rise_cnt - rise0);

    // clear in the same cycle as the 16th count: set wins
    valid_i = 1'b1; data_i = 32'h5A5A0002;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 16) begin
        check("to2_before_16", timeout_o, 0);
        clear_i = 1'b1;
      end
    end
    clear_i = 1'b0;
    check("to2_set_wins", timeout_o, 1);
    @(posedge clk); #1;
    check("to2_sticky", timeout_o, 1);
    ack_force = 1'b1;
    wait_req(1'b0, 20);
    ack_force = 1'b0;
    wait_ready(20);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    check("to2_cleared", timeout_o, 0);

    // reset in REQ_UP while the receiver holds ack high
    wait_ready(20);
    valid_i = 1'b1; data_i = 32'h77778888;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_req(1'b1, 10);
    ack_force = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_req", req_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_busy", busy_o, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("init_hold_ready", ready_o, 0);
    check("init_hold_state", state_o, 0);
    ack_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_ack_s_low_ready", ready_o, 0);
    @(posedge clk); #1;
    check("init_to_idle", ready_o, 1);
    echo = 1'b1;

    // three-stage synchroniser, echo ack: 10 cycles per word
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready3) break;
    end
    check("wait_ready3", ready3, 1);
    valid3 = 1'b1; data3_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    valid3 = 1'b0; data3_i = 32'hFFFFFFFF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("s3_req_k%0d", k), req3, (k >= 1 && k <= 4));
      check($sformatf("s3_ready_k%0d", k), ready3, (k == 9));
      if (k == 1) check("s3_data", data3_o, 32'hCAFEF00D);
      if (k == 9) begin
        valid3 = 1'b1;
        data3_i = 32'h0BADF00D;
      end
    end
    valid3 = 1'b0;
    check("s3_second_accept_state", state3, 2);
    check("s3_second_data", data3_o, 32'h0BADF00D);
    check("s3_timeout_off", timeout3, 0);

    repeat (12) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
